pipe_ctrl_tracker: RTL and testbench

- Consumes the per-instruction control bundle produced by the opcode decoder in ID.
- Carries the bundle through the ID/EX, EX/MEM and MEM/WB control registers.
- Generates load-use stall, taken-branch/jump flush and EX-stage forwarding selects.
- Runs a halt-drain state machine so the pipeline retires cleanly on a HALT opcode.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_tracker_fwd_unit.sv | 24 ++
 rtl/pipe_ctrl_tracker.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl_tracker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control tracker.
package pipe_ctrl_pkg;

  localparam int unsigned CTRL_W = 10;

  // Decoder bundle, MSB first as produced by the ID-stage opcode decoder.
  typedef struct packed {
    logic       alu_src;
    logic       jal_to_reg;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       branch;
    logic       spare;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [6:0] OP_HALT = 7'b0000000;

endpackage

// File: rtl/pipe_ctrl_tracker_fwd_unit.sv
// EX-operand forwarding select; EX/MEM result beats MEM/WB, x0 never forwards.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [REG_AW-1:0] ex_rs,
  output logic [1:0]        fwd_sel_c
);

  always_comb begin
    fwd_sel_c = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      fwd_sel_c = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      fwd_sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_ctrl_tracker.sv
// Carries decoded control through ID/EX, EX/MEM, MEM/WB and generates
// stall, flush, forwarding selects and the HALT drain sequence.
module pipe_ctrl_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_halt,
  input  logic              ex_redirect,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic              stall,
  output logic              flush_ifid,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              halted_q;
  logic              bubble, freeze, hz;

  ctrl_t             ex_q, mem_q, wb_q;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q, mem_rd_q, wb_rd_q;

  assign hz = ex_q.mem_read && (ex_rd_q != '0) &&
              ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));

  // Next-state and hazard controls; redirect always outranks load-use.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    flush_ifid = 1'b0;
    bubble     = 1'b0;
    freeze     = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          flush_ifid = 1'b1;
          bubble     = 1'b1;
        end else if (hz) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end else if (id_halt) begin
          state_d = DRAIN;
          cnt_d   = '0;
          bubble  = 1'b1;
        end
      end
      DRAIN: begin
        bubble = 1'b1;
        if (ex_redirect) begin
          flush_ifid = 1'b1;
          state_d    = RUN;
          cnt_d      = '0;
        end else begin
          stall = 1'b1;
          if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
            state_d = HALTED;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HALTED: begin
        stall  = 1'b1;
        bubble = 1'b1;
        freeze = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == HALTED);
    end
  end

  // Stage registers; a bubble clears the whole ID/EX slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
      ex_rd_q  <= '0;
      mem_q    <= '0;
      mem_rd_q <= '0;
      wb_q     <= '0;
      wb_rd_q  <= '0;
    end else if (freeze) begin
      ex_q     <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
      ex_rd_q  <= '0;
      mem_q    <= '0;
      mem_rd_q <= '0;
      wb_q     <= '0;
      wb_rd_q  <= '0;
    end else begin
      if (bubble) begin
        ex_q     <= '0;
        ex_rs1_q <= '0;
        ex_rs2_q <= '0;
        ex_rd_q  <= '0;
      end else begin
        ex_q     <= ctrl_t'(id_ctrl);
        ex_rs1_q <= id_rs1;
        ex_rs2_q <= id_rs2;
        ex_rd_q  <= id_rd;
      end
      mem_q    <= ex_q;
      mem_rd_q <= ex_rd_q;
      wb_q     <= mem_q;
      wb_rd_q  <= mem_rd_q;
    end
  end

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .mem_reg_write (mem_q.reg_write),
    .mem_rd        (mem_rd_q),
    .wb_reg_write  (wb_q.reg_write),
    .wb_rd         (wb_rd_q),
    .ex_rs         (ex_rs1_q),
    .fwd_sel_c     (fwd_a)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .mem_reg_write (mem_q.reg_write),
    .mem_rd        (mem_rd_q),
    .wb_reg_write  (wb_q.reg_write),
    .wb_rd         (wb_rd_q),
    .ex_rs         (ex_rs2_q),
    .fwd_sel_c     (fwd_b)
  );

  assign ex_ctrl  = ex_q;
  assign mem_ctrl = mem_q;
  assign wb_ctrl  = wb_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// Directed scoreboard bench for pipe_ctrl_tracker.
module tb_pipe_ctrl_tracker;

  localparam logic [9:0] C_NOP  = 10'h000;
  localparam logic [9:0] C_LW   = 10'h2E0;
  localparam logic [9:0] C_ADD  = 10'h048;
  localparam logic [9:0] C_ADDI = 10'h240;
  localparam logic [9:0] C_BEQ  = 10'h006;

  localparam int S_EX = 0, S_MEM = 1, S_WB = 2, S_STALL = 3,
                 S_FLUSH = 4, S_FWDA = 5, S_FWDB = 6, S_HALT = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] id_ctrl = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_halt = 1'b0, ex_redirect = 1'b0;
  logic [9:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic       stall, flush_ifid, halted;
  logic [1:0] fwd_a, fwd_b;

  pipe_ctrl_tracker #(.REG_AW(5), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_halt(id_halt),
    .ex_redirect(ex_redirect), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
    .wb_ctrl(wb_ctrl), .stall(stall), .flush_ifid(flush_ifid),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         sig;
    logic [9:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [9:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due this cycle and compares mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.sig)
        S_EX:    act = ex_ctrl;
        S_MEM:   act = mem_ctrl;
        S_WB:    act = wb_ctrl;
        S_STALL: act = 10'(stall);
        S_FLUSH: act = 10'(flush_ifid);
        S_FWDA:  act = 10'(fwd_a);
        S_FWDB:  act = 10'(fwd_b);
        default: act = 10'(halted);
      endcase
      n_checks++;
      if (act !== e.val) begin
        n_errors++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, act, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [9:0] c, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic h, input logic rdr);
    tick();
    id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_halt = h; ex_redirect = rdr;
  endtask

  task automatic chk(input int sig, input logic [9:0] v, input string nm);
    sb.push_back('{cyc, sig, v, nm});
  endtask

  initial begin
    // Reset state
    tick();
    chk(S_EX, C_NOP, "rst_ex");     chk(S_MEM, C_NOP, "rst_mem");
    chk(S_WB, C_NOP, "rst_wb");     chk(S_STALL, 10'd0, "rst_stall");
    chk(S_FLUSH, 10'd0, "rst_flush"); chk(S_FWDA, 10'd0, "rst_fwda");
    chk(S_FWDB, 10'd0, "rst_fwdb"); chk(S_HALT, 10'd0, "rst_halted");
    tick();
    rst_n = 1'b1;

    // Load-use: LW x5 then ADD using x5
    drv(C_LW, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
    chk(S_STALL, 10'd0, "lu_nostall");
    drv(C_ADD, 5'd5, 5'd3, 5'd6, 1'b0, 1'b0);
    chk(S_STALL, 10'd1, "lu_stall");   chk(S_EX, C_LW, "lu_ex_lw");
    drv(C_ADD, 5'd5, 5'd3, 5'd6, 1'b0, 1'b0);
    chk(S_STALL, 10'd0, "lu_stall_once"); chk(S_EX, C_NOP, "lu_bubble");
    chk(S_MEM, C_LW, "lu_mem_lw");     chk(S_FWDA, 10'd0, "lu_fwda_bub");
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk(S_EX, C_ADD, "lu_ex_add");     chk(S_WB, C_LW, "lu_wb_lw");
    chk(S_FWDA, 10'b01, "lu_fwda_wb"); chk(S_FWDB, 10'b00, "lu_fwdb_rf");

    // Forward priority: x7 in both MEM and WB
    drv(C_ADDI, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);
    drv(C_ADD, 5'd2, 5'd4, 5'd7, 1'b0, 1'b0);
    drv(C_ADD, 5'd9, 5'd7, 5'd8, 1'b0, 1'b0);
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk(S_FWDB, 10'b10, "prio_fwdb_mem"); chk(S_FWDA, 10'b00, "prio_fwda_rf");

    // Same pattern on x0: never forwards
    drv(C_ADDI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    drv(C_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    drv(C_ADD, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0);
    drv(C_ADD, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0);
    chk(S_FWDB, 10'b00, "x0_fwdb");   chk(S_FWDA, 10'b00, "x0_fwda");

    // MEM-only forward on operand A
    drv(C_ADD, 5'd10, 5'd0, 5'd11, 1'b0, 1'b0);
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk(S_FWDA, 10'b10, "mem_fwda");  chk(S_FWDB, 10'b00, "mem_fwdb");

    // Redirect together with load-use
    drv(C_LW, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0);
    drv(C_BEQ, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1);
    chk(S_STALL, 10'd0, "rd_stall");  chk(S_FLUSH, 10'd1, "rd_flush");
    chk(S_EX, C_LW, "rd_ex_lw");
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk(S_EX, C_NOP, "rd_bubble");    chk(S_FLUSH, 10'd0, "rd_flush_off");
    chk(S_MEM, C_LW, "rd_mem_lw");

    // Halt drain
    drv(C_ADD, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk(S_STALL, 10'd0, "h0_stall");  chk(S_HALT, 10'd0, "h0_halted");
    chk(S_EX, C_ADD, "h0_ex_add");
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk(S_STALL, 10'd1, "h1_stall");  chk(S_HALT, 10'd0, "h1_halted");
    chk(S_EX, C_NOP, "h1_ex_bub");
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk(S_STALL, 10'd1, "h2_stall");  chk(S_HALT, 10'd0, "h2_halted");
    chk(S_WB, C_ADD, "h2_wb_add");
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk(S_STALL, 10'd1, "h3_stall");  chk(S_HALT, 10'd0, "h3_halted");
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk(S_HALT, 10'd1, "h4_halted");  chk(S_STALL, 10'd1, "h4_stall");
    chk(S_WB, C_NOP, "h4_wb_zero");
    drv(C_ADD, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0);
    chk(S_HALT, 10'd1, "h5_halted");  chk(S_EX, C_NOP, "h5_ex_zero");

    // Asynchronous reset out of HALTED, sampled before any clock edge
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    chk(S_HALT, 10'd0, "arst_halted"); chk(S_STALL, 10'd0, "arst_stall");
    chk(S_EX, C_NOP, "arst_ex");
    tick();
    rst_n = 1'b1;

    // Wrong-path halt: redirect during drain
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk(S_STALL, 10'd0, "wp0_stall");
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    chk(S_STALL, 10'd0, "wp1_stall"); chk(S_FLUSH, 10'd1, "wp1_flush");
    drv(C_ADD, 5'd0, 5'd0, 5'd12, 1'b0, 1'b0);
    chk(S_STALL, 10'd0, "wp2_stall"); chk(S_HALT, 10'd0, "wp2_halted");
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk(S_EX, C_ADD, "wp3_ex_add");   chk(S_STALL, 10'd0, "wp3_stall");
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk(S_HALT, 10'd0, "wp4_halted");
    drv(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk(S_HALT, 10'd0, "wp5_halted"); chk(S_STALL, 10'd0, "wp5_stall");

    tick();
    tick();
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
